// File: rtl/cache_req_bank_scheduler_pkg.sv
// rtl/cache_req_bank_scheduler_pkg.sv - shared config for the cache request bank scheduler
//
// Purpose: default geometry, the bank-index extraction helper and the
// scheduler state enum shared by the interface, lane picker and top.
package cache_req_bank_scheduler_pkg;

    localparam int DEF_NUM_BANKS       = 4;
    localparam int DEF_NUM_REQUESTS    = 4;
    localparam int DEF_WORD_ADDR_WIDTH = 30;
    localparam int DEF_BANK_SEL_LSB    = 2;
    localparam int BANK_SEL_BITS       = $clog2(DEF_NUM_BANKS);

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } sched_state_e;

    // Bank index of a word address. NUM_BANKS is a power of two, so masking
    // with (num_banks - 1) keeps exactly log2(num_banks) bits above lsb.
    function automatic logic [31:0] bank_index(input logic [63:0] addr,
                                               input int          lsb,
                                               input int          num_banks);
        return 32'((addr >> lsb) & 64'(num_banks - 1));
    endfunction

endpackage

// File: rtl/cache_req_bank_scheduler_if.sv
// rtl/cache_req_bank_scheduler_if.sv - core request / per-bank issue bundle
//
// Signals:
//   core_req_valid  per-lane valid of the current batch (core -> sched)
//   core_req_addr   per-lane word address              (core -> sched)
//   core_req_ready  batch fully accepted this cycle     (sched -> core)
//   per_bank_valid  lane mask issued to each bank       (sched -> banks)
//   per_bank_ready  bank accepts its issued lanes       (banks -> sched)
// Modports: master = core/bank environment, slave = scheduler.
interface cache_req_bank_scheduler_if
    import cache_req_bank_scheduler_pkg::*;
#(
    parameter int NUM_BANKS       = DEF_NUM_BANKS,
    parameter int NUM_REQUESTS    = DEF_NUM_REQUESTS,
    parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH
);
    logic [NUM_REQUESTS-1:0]                      core_req_valid;
    logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0] core_req_addr;
    logic                                         core_req_ready;
    logic [NUM_BANKS-1:0][NUM_REQUESTS-1:0]       per_bank_valid;
    logic [NUM_BANKS-1:0]                         per_bank_ready;

    modport master (
        output core_req_valid, core_req_addr, per_bank_ready,
        input  core_req_ready, per_bank_valid
    );

    modport slave (
        input  core_req_valid, core_req_addr, per_bank_ready,
        output core_req_ready, per_bank_valid
    );
endinterface

// File: rtl/cache_req_bank_scheduler_lane_select.sv
// rtl/cache_req_bank_scheduler_lane_select.sv - per-bank lowest-index lane picker
//
// Module cache_lane_select, one instance per bank.
// Ports:
//   eff        lanes still eligible this cycle
//   addr       per-lane word address
//   lane_mask  lanes issued to bank BANK_ID (one-hot or zero; multi-hot
//              when CACHE_SCHED_MERGE_EN merges identical addresses)
// Optional macro: CACHE_SCHED_MERGE_EN.
module cache_lane_select
    import cache_req_bank_scheduler_pkg::*;
#(
    parameter int NUM_BANKS       = DEF_NUM_BANKS,
    parameter int NUM_REQUESTS    = DEF_NUM_REQUESTS,
    parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH,
    parameter int BANK_SEL_LSB    = DEF_BANK_SEL_LSB,
    parameter int BANK_ID         = 0
) (
    input  logic [NUM_REQUESTS-1:0]                      eff,
    input  logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0] addr,
    output logic [NUM_REQUESTS-1:0]                      lane_mask
);

    logic [NUM_REQUESTS-1:0] hit;
    logic [NUM_REQUESTS-1:0] first;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            hit[i] = eff[i] &&
                     (bank_index(64'(addr[i]), BANK_SEL_LSB, NUM_BANKS) == 32'(BANK_ID));
        end
        // Two's-complement trick isolates the lowest set bit (fixed priority).
        first = hit & (~hit + NUM_REQUESTS'(1));
    end

`ifdef CACHE_SCHED_MERGE_EN
    logic [WORD_ADDR_WIDTH-1:0] sel_addr;

    // Identical addresses always map to the same bank, so comparing only
    // against lanes that already hit this bank is sufficient.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (first[i]) sel_addr = addr[i];
        end
        lane_mask = first;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (hit[i] && (addr[i] == sel_addr)) lane_mask[i] = 1'b1;
        end
    end
`else
    assign lane_mask = first;
`endif

endmodule

// File: rtl/cache_req_bank_scheduler.sv
// rtl/cache_req_bank_scheduler.sv - replays bank-conflicting lanes of a core request batch
//
// Purpose: each cycle issues at most one lane (or one merged address group)
// per bank, keeps the unretired lanes in a pending mask and replays them on
// later cycles; core_req_ready pulses in the cycle the last lane retires.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   bus (slave)        core request batch in, per-bank issue out
//   sched_busy         batch partially issued (REPLAY)
//   perf_conflict_cnt  saturating count of REPLAY cycles
// Optional macro: CACHE_SCHED_MERGE_EN (merge identical addresses per bank).
module cache_req_bank_scheduler
    import cache_req_bank_scheduler_pkg::*;
#(
    parameter int NUM_BANKS       = DEF_NUM_BANKS,
    parameter int NUM_REQUESTS    = DEF_NUM_REQUESTS,
    parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH,
    parameter int BANK_SEL_LSB    = DEF_BANK_SEL_LSB
) (
    input  logic                              clk,
    input  logic                              reset,
    cache_req_bank_scheduler_if.slave         bus,
    output logic                              sched_busy,
    output logic [31:0]                       perf_conflict_cnt
);

    sched_state_e            state_q, state_d;
    logic [NUM_REQUESTS-1:0] pending_q, pending_d;
    logic [31:0]             perf_cnt_q, perf_cnt_d;

    logic [NUM_REQUESTS-1:0] eff;
    logic [NUM_REQUESTS-1:0] accepted;
    logic [NUM_REQUESTS-1:0] lane_mask [NUM_BANKS];
    logic                    batch_done;

    always_comb begin
        eff = (state_q == REPLAY) ? (pending_q & bus.core_req_valid) : bus.core_req_valid;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        cache_lane_select #(
            .NUM_BANKS       (NUM_BANKS),
            .NUM_REQUESTS    (NUM_REQUESTS),
            .WORD_ADDR_WIDTH (WORD_ADDR_WIDTH),
            .BANK_SEL_LSB    (BANK_SEL_LSB),
            .BANK_ID         (b)
        ) u_lane_select (
            .eff       (eff),
            .addr      (bus.core_req_addr),
            .lane_mask (lane_mask[b])
        );
    end

    always_comb begin
        accepted = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            accepted = accepted | (lane_mask[b] & {NUM_REQUESTS{bus.per_bank_ready[b]}});
        end
        batch_done = ((eff & ~accepted) == '0);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (!batch_done) begin
                    state_d   = REPLAY;
                    pending_d = eff & ~accepted;
                end
            end
            REPLAY: begin
                if (batch_done) begin
                    state_d   = IDLE;
                    pending_d = '0;
                end else begin
                    pending_d = pending_q & ~accepted;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if ((state_q == REPLAY) && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            perf_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            perf_cnt_q <= perf_cnt_d;
        end
    end

    // Outputs are gated by reset so they drop in the same cycle reset asserts.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bus.per_bank_valid[b] = reset ? lane_mask[b] : '0;
        end
        bus.core_req_ready = reset && batch_done;
        sched_busy         = reset && (state_q == REPLAY);
        perf_conflict_cnt  = reset ? perf_cnt_q : 32'd0;
    end

endmodule
